// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the sequencer state encoding used by serial_add_ctrl.
package serial_add_pkg;

  localparam int STATE_W = 2;

  // Value 3 is unused. The sequencer treats it as illegal and returns to IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder made from two half adders and an OR of their carries.
// The serial controller time-shares this one cell across every bit position.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  // The two half-adder carries can never both be high, so OR gives the majority.
  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder. It is the basic cell that the full-adder stage is built from.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder. It processes the operands LSB-first, one bit per clock,
// through a single fa_cell, and uses valid/ready handshakes on both the operand side and the result side.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_ready_q;
  logic             busy_q;
  logic             done_valid_q;

  logic [WIDTH-1:0] a_sr_d;
  logic [WIDTH-1:0] b_sr_d;
  logic [WIDTH-1:0] sum_sr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    a_sr_d            = a_sr_q >> 1;
    b_sr_d            = b_sr_q >> 1;
    sum_sr_d          = sum_sr_q >> 1;
    sum_sr_d[WIDTH-1] = fa_s;
    cnt_d             = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      a_sr_q        <= '0;
      b_sr_q        <= '0;
      sum_sr_q      <= '0;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            a_sr_q        <= a_in;
            b_sr_q        <= b_in;
            carry_q       <= cin;
            cnt_q         <= '0;
            sum_sr_q      <= '0;
            state_q       <= ST_RUN;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end

        ST_RUN: begin
          a_sr_q   <= a_sr_d;
          b_sr_q   <= b_sr_d;
          sum_sr_q <= sum_sr_d;
          carry_q  <= fa_c;
          cnt_q    <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b1;
          end
        end

        // The result registers are left untouched here, so backpressure can last any length of time.
        ST_DONE: begin
          if (done_ready) begin
            state_q       <= ST_IDLE;
            done_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q       <= ST_IDLE;
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          done_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign done_valid  = done_valid_q;
  assign sum_out     = sum_sr_q;
  assign cout        = carry_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial multi-bit adder controller.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake, then processes them LSB-first, one bit per clock, through a single full-adder cell built from two half-adder instances.
- Presents the WIDTH-bit sum and carry-out through a valid/ready result handshake.
- Used where area matters more than latency. It is the sequencer that time-shares the half-adder datapath across all bit positions.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range is WIDTH >= 1.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  operands and cin are valid.
- start_ready  out  1  controller can accept operands (high only in IDLE).
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- cin  in  1  carry-in.
- busy  out  1  high in RUN.
- done_valid  out  1  result valid (high only in DONE).
- done_ready  in  1  consumer accepts result.
- sum_out  out  WIDTH  sum result.
- cout  out  1  carry-out.

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high at a rising clk edge resets the block.
- Reset state:
  - state = IDLE.
  - a_sr, b_sr, sum_sr = 0; carry_q = 0; cnt = 0.
  - start_ready = 1, busy = 0, done_valid = 0, sum_out = 0, cout = 0.
- States: IDLE, RUN, DONE. Encoding is 2-bit: IDLE = 0, RUN = 1, DONE = 2. Value 3 is illegal and returns to IDLE on the next edge.
- IDLE:
  - start_ready = 1.
  - On an edge with start_valid = 1: load a_sr <= a_in, b_sr <= b_in, carry_q <= cin, cnt <= 0, clear sum_sr, go to RUN.
  - On an edge with start_valid = 0: stay in IDLE.
- RUN:
  - The full-adder cell computes s = a_sr[0] ^ b_sr[0] ^ carry_q and c = majority(a_sr[0], b_sr[0], carry_q).
  - Each edge: a_sr and b_sr shift right by 1; sum_sr shifts right with s inserted at bit WIDTH-1; carry_q <= c; cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: go to DONE.
  - start_valid is ignored and start_ready = 0.
- DONE:
  - done_valid = 1, sum_out = sum_sr, cout = carry_q.
  - On an edge with done_ready = 1: go to IDLE.
  - Otherwise hold the state and all outputs unchanged, for unbounded backpressure.
- Latency: done_valid is high in the cycle following the WIDTH-th rising edge after the accepting edge.
- Throughput: minimum WIDTH+2 cycles from one accept to the next, because IDLE must be re-entered.
- sum_out and cout come directly from sum_sr and carry_q. In IDLE they keep the last result until the next accept clears sum_sr, so they are only meaningful while done_valid = 1.
- Arithmetic: {cout, sum_out} == a_in + b_in + cin, computed modulo 2^(WIDTH+1).
- cnt width is $clog2(WIDTH+1). For WIDTH = 1 the block goes RUN -> DONE after one edge.
- Reset during RUN or DONE aborts the operation; no done_valid is produced.
- Reset has priority over every handshake sampled on the same edge.
- Operand inputs are sampled only on the accepting edge. Changes at any other time have no effect.

Decomposition:
- Shared package serial_add_pkg holds:
  - the state typedef/constants (ST_IDLE, ST_RUN, ST_DONE);
  - the state width constant (2).
- One sub-module, fa_cell: a purely combinational full adder with inputs a, b, ci and outputs s, co.
  - Built from two instances of the existing half-adder module plus an OR of their carries.
  - serial_add_ctrl instantiates fa_cell once; all sequencing lives in serial_add_ctrl.

Test Plan:
- Basic sum: WIDTH = 8, a = 8'h5A, b = 8'h3C, cin = 0, done_ready = 1 -> done_valid rises 8 edges after accept with sum_out = 8'h96 and cout = 0, then IDLE next edge.
- Carry ripple: a = 8'hFF, b = 8'h01, cin = 0 -> sum_out = 8'h00, cout = 1. Separately, a = 8'hFF, b = 8'hFF, cin = 1 -> sum_out = 8'hFF, cout = 1.
- Backpressure: hold done_ready = 0 for 5 cycles in DONE -> done_valid, sum_out and cout are stable for all 5 cycles; the block returns to IDLE only on the edge where done_ready = 1.
- Busy rejection: hold start_valid = 1 with changing a_in during RUN -> start_ready = 0, the result reflects only the operands captured at the accepting edge, and no second accept occurs before IDLE.
- Reset mid-operation: assert rst at cnt = 3 -> next cycle is IDLE with all outputs at reset values, no done_valid; a following accept of 8'h01 + 8'h01 gives sum_out = 8'h02.
- Random sweep with WIDTH = 1 and WIDTH = 8 (≥ 1000 operand triples, random done_ready stalls) -> {cout, sum_out} matches the reference sum for every result.
